// File: rtl/stack_ptr_gen_if.sv
// stack_ptr_gen_if: command / data-bus bundle for the stack pointer block.
//   cmd_valid_i/cmd_op_i/cmd_ready_o : command handshake (accept = valid & ready)
//   abort_i                          : abort an in-flight LOAD/OUT
//   dat_i/dat_valid_i                : LSB-first load beats into the block
//   dat_o/dat_oe_o                   : LSB-first read beats out of the block
//   sp_addr_o/wrap_o                 : current SP and sticky wrap flag
// Signal names are from the block's point of view (_i into, _o out of it).
interface stack_ptr_gen_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              cmd_valid_i;
  logic [2:0]        cmd_op_i;
  logic              cmd_ready_o;
  logic              abort_i;
  logic [DATA_W-1:0] dat_i;
  logic              dat_valid_i;
  logic [DATA_W-1:0] dat_o;
  logic              dat_oe_o;
  logic [ADDR_W-1:0] sp_addr_o;
  logic              wrap_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, abort_i, dat_i, dat_valid_i,
    output cmd_ready_o, dat_o, dat_oe_o, sp_addr_o, wrap_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, abort_i, dat_i, dat_valid_i,
    input  cmd_ready_o, dat_o, dat_oe_o, sp_addr_o, wrap_o
  );
endinterface

// File: rtl/stack_ptr_gen.sv
// stack_ptr_gen: parametrised stack pointer for the 8080 core family.
//   clk50M_i : clock, all state on rising edge
//   rst_ni   : async active-low reset (release expected synchronous to clk50M_i)
//   bus      : stack_ptr_gen_if slave port
//     INC/DEC  : sp +/- STEP modulo 2**ADDR_W, sticky wrap_o on carry/borrow
//     LOAD     : BEATS LSB-first beats into a shadow, SP updated only at commit
//     OUT      : snapshot of SP streamed LSB-first, one beat per cycle
//     abort_i  : drops an in-flight LOAD/OUT, SP and wrap_o untouched
module stack_ptr_gen #(
  parameter int                 ADDR_W = 16,
  parameter int                 DATA_W = 8,
  parameter logic [ADDR_W-1:0]  STEP   = 1,
  parameter logic [ADDR_W-1:0]  SP_RST = '0
) (
  input  logic            clk50M_i,
  input  logic            rst_ni,
  stack_ptr_gen_if.slave  bus
);

  localparam int BEATS = ADDR_W / DATA_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [2:0] OP_INC  = 3'd1;
  localparam logic [2:0] OP_DEC  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_OUT  = 3'd4;

  logic [1:0]        r_state;
  logic [BW-1:0]     r_beat;
  logic [ADDR_W-1:0] r_shadow;   // load assembly buffer, or OUT snapshot
  logic [ADDR_W-1:0] r_sp;
  logic              r_wrap;

  logic [ADDR_W:0]   w_inc;
  logic [ADDR_W:0]   w_dec;
  logic [ADDR_W-1:0] w_assembled;
  logic [DATA_W-1:0] w_beat_dat;
  logic              w_last;

  // Extra top bit carries the carry (INC) or borrow (DEC) out of the SP.
  assign w_inc  = {1'b0, r_sp} + {1'b0, STEP};
  assign w_dec  = {1'b0, r_sp} - {1'b0, STEP};
  assign w_last = (r_beat == LAST);

  // Shadow with the current beat replaced by dat_i; on the last beat this is
  // the full value committed to SP in the same edge.
  always_comb begin
    w_assembled = r_shadow;
    w_beat_dat  = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (r_beat == BW'(b)) begin
        w_assembled[b*DATA_W +: DATA_W] = bus.dat_i;
        w_beat_dat                      = r_shadow[b*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk50M_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_beat   <= '0;
      r_shadow <= '0;
      r_sp     <= SP_RST;
      r_wrap   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid_i) begin
            case (bus.cmd_op_i)
              OP_INC: begin
                r_sp <= w_inc[ADDR_W-1:0];
                if (w_inc[ADDR_W]) r_wrap <= 1'b1;
              end
              OP_DEC: begin
                r_sp <= w_dec[ADDR_W-1:0];
                if (w_dec[ADDR_W]) r_wrap <= 1'b1;
              end
              OP_LOAD: begin
                r_beat  <= '0;
                r_state <= S_LOAD;
              end
              OP_OUT: begin
                r_shadow <= r_sp;
                r_beat   <= '0;
                r_state  <= S_OUT;
              end
              default: ;
            endcase
          end
        end
        S_LOAD: begin
          // Abort outranks a same-cycle last beat: nothing is committed.
          if (bus.abort_i) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_shadow <= '0;
          end else if (bus.dat_valid_i) begin
            r_shadow <= w_assembled;
            if (w_last) begin
              r_sp    <= w_assembled;
              r_wrap  <= 1'b0;
              r_beat  <= '0;
              r_state <= S_IDLE;
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        S_OUT: begin
          if (bus.abort_i || w_last) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_shadow <= '0;
          end else begin
            r_beat <= r_beat + BW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end

  // Every cycle spent in OUT is a driven beat, so the enable is the state.
  assign bus.cmd_ready_o = (r_state == S_IDLE);
  assign bus.dat_oe_o    = (r_state == S_OUT);
  assign bus.dat_o       = (r_state == S_OUT) ? w_beat_dat : '0;
  assign bus.sp_addr_o   = r_sp;
  assign bus.wrap_o      = r_wrap;

endmodule

// File: tb/tb_stack_ptr_gen.sv
module tb_stack_ptr_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stack_ptr_gen_if #(.ADDR_W(16), .DATA_W(8)) ifm ();
  stack_ptr_gen_if #(.ADDR_W(32), .DATA_W(8)) if32 ();
  stack_ptr_gen_if #(.ADDR_W(8),  .DATA_W(8)) if8 ();

  stack_ptr_gen #(.ADDR_W(16), .DATA_W(8), .STEP(16'd1), .SP_RST(16'h0000)) dut (
    .clk50M_i(clk), .rst_ni(rst_n), .bus(ifm.slave));
  stack_ptr_gen #(.ADDR_W(32), .DATA_W(8), .STEP(32'd2), .SP_RST(32'h0000_1000)) dut32 (
    .clk50M_i(clk), .rst_ni(rst_n), .bus(if32.slave));
  stack_ptr_gen #(.ADDR_W(8),  .DATA_W(8), .STEP(8'd1),  .SP_RST(8'h80)) dut8 (
    .clk50M_i(clk), .rst_ni(rst_n), .bus(if8.slave));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // main DUT observation: {ready, oe, wrap, dat[7:0], sp[15:0]}
  function automatic logic [63:0] obs_m();
    return {37'b0, ifm.cmd_ready_o, ifm.dat_oe_o, ifm.wrap_o, ifm.dat_o, ifm.sp_addr_o};
  endfunction

  function automatic logic [63:0] pk(input logic rdy, input logic oe, input logic wr,
                                     input logic [7:0] q, input logic [15:0] sp);
    return {37'b0, rdy, oe, wr, q, sp};
  endfunction

  task automatic drive_m(input logic v, input logic [2:0] op, input logic ab,
                         input logic dv, input logic [7:0] d);
    ifm.cmd_valid_i = v; ifm.cmd_op_i = op; ifm.abort_i = ab;
    ifm.dat_valid_i = dv; ifm.dat_i = d;
  endtask

  task automatic drive_32(input logic v, input logic [2:0] op, input logic dv, input logic [7:0] d);
    if32.cmd_valid_i = v; if32.cmd_op_i = op; if32.abort_i = 1'b0;
    if32.dat_valid_i = dv; if32.dat_i = d;
  endtask

  task automatic drive_8(input logic v, input logic [2:0] op, input logic dv, input logic [7:0] d);
    if8.cmd_valid_i = v; if8.cmd_op_i = op; if8.abort_i = 1'b0;
    if8.dat_valid_i = dv; if8.dat_i = d;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic v; logic [2:0] op; logic ab; logic dv; logic [7:0] d;
    logic [15:0] sp; logic rdy; logic oe; logic wr; logic [7:0] q;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [2:0] op, input logic ab,
                              input logic dv, input logic [7:0] d, input logic [15:0] sp,
                              input logic rdy, input logic oe, input logic wr, input logic [7:0] q);
    vec_t t;
    t.v = v; t.op = op; t.ab = ab; t.dv = dv; t.d = d;
    t.sp = sp; t.rdy = rdy; t.oe = oe; t.wr = wr; t.q = q;
    return t;
  endfunction

  // ---------------- reference model (main DUT) ----------------
  int       m_sp;
  bit       m_wrap;
  int       m_mode;        // 0 idle, 1 load, 2 out
  byte      m_loadq[$];
  byte      m_outq[$];

  function automatic logic [63:0] model_obs();
    logic [7:0] q;
    q = (m_mode == 2) ? m_outq[0] : 8'h00;
    return pk(m_mode == 0, m_mode == 2, m_wrap, q, m_sp[15:0]);
  endfunction

  task automatic model_step();
    int t;
    if (m_mode == 0) begin
      if (ifm.cmd_valid_i) begin
        case (ifm.cmd_op_i)
          3'd1: begin t = m_sp + 1; if (t >= 65536) begin m_wrap = 1; t -= 65536; end m_sp = t; end
          3'd2: begin t = m_sp - 1; if (t < 0) begin m_wrap = 1; t += 65536; end m_sp = t; end
          3'd3: begin m_mode = 1; m_loadq.delete(); end
          3'd4: begin
            m_mode = 2; m_outq.delete();
            m_outq.push_back(byte'(m_sp % 256));
            m_outq.push_back(byte'(m_sp / 256));
          end
          default: ;
        endcase
      end
    end else if (ifm.abort_i) begin
      m_mode = 0; m_loadq.delete(); m_outq.delete();
    end else if (m_mode == 1) begin
      if (ifm.dat_valid_i) begin
        m_loadq.push_back(byte'(ifm.dat_i));
        if (m_loadq.size() == 2) begin
          m_sp   = int'(unsigned'(m_loadq[0])) + 256 * int'(unsigned'(m_loadq[1]));
          m_wrap = 0;
          m_mode = 0;
          m_loadq.delete();
        end
      end
    end else begin
      void'(m_outq.pop_front());
      if (m_outq.size() == 0) m_mode = 0;
    end
  endtask

  logic [31:0] exp32;

  initial begin
    rst_n = 1'b0;
    drive_m(0, 0, 0, 0, 0);
    drive_32(0, 0, 0, 0);
    drive_8(0, 0, 0, 0);

    // table: inputs for one cycle, outputs expected after that edge
    tbl.push_back(mk(1,3,0,0,8'h00, 16'h0000,0,0,0,8'h00)); // LOAD accept
    tbl.push_back(mk(0,0,0,1,8'h34, 16'h0000,0,0,0,8'h00));
    tbl.push_back(mk(0,0,0,0,8'h00, 16'h0000,0,0,0,8'h00)); // stall
    tbl.push_back(mk(0,0,0,0,8'h00, 16'h0000,0,0,0,8'h00)); // stall
    tbl.push_back(mk(0,0,0,1,8'h12, 16'h1234,1,0,0,8'h00)); // commit
    tbl.push_back(mk(1,4,0,0,8'h00, 16'h1234,0,1,0,8'h34)); // OUT beat 0
    tbl.push_back(mk(0,0,0,0,8'h00, 16'h1234,0,1,0,8'h12)); // OUT beat 1
    tbl.push_back(mk(0,0,0,0,8'h00, 16'h1234,1,0,0,8'h00));
    tbl.push_back(mk(1,3,0,0,8'h00, 16'h1234,0,0,0,8'h00));
    tbl.push_back(mk(0,0,0,1,8'hFF, 16'h1234,0,0,0,8'h00));
    tbl.push_back(mk(0,0,0,1,8'hFF, 16'hFFFF,1,0,0,8'h00));
    tbl.push_back(mk(1,1,0,0,8'h00, 16'h0000,1,0,1,8'h00)); // INC wraps
    tbl.push_back(mk(1,2,0,0,8'h00, 16'hFFFF,1,0,1,8'h00)); // DEC wraps, sticky
    tbl.push_back(mk(1,3,0,0,8'h00, 16'hFFFF,0,0,1,8'h00));
    tbl.push_back(mk(0,0,0,1,8'h00, 16'hFFFF,0,0,1,8'h00));
    tbl.push_back(mk(0,0,0,1,8'h01, 16'h0100,1,0,0,8'h00)); // LOAD clears wrap
    tbl.push_back(mk(1,3,0,0,8'h00, 16'h0100,0,0,0,8'h00));
    tbl.push_back(mk(0,0,0,1,8'h00, 16'h0100,0,0,0,8'h00));
    tbl.push_back(mk(0,0,0,1,8'h10, 16'h1000,1,0,0,8'h00));
    tbl.push_back(mk(1,2,0,0,8'h00, 16'h0FFF,1,0,0,8'h00)); // back-to-back DEC
    tbl.push_back(mk(1,2,0,0,8'h00, 16'h0FFE,1,0,0,8'h00));
    tbl.push_back(mk(1,2,0,0,8'h00, 16'h0FFD,1,0,0,8'h00));
    tbl.push_back(mk(1,3,0,0,8'h00, 16'h0FFD,0,0,0,8'h00));
    tbl.push_back(mk(0,0,0,1,8'hAA, 16'h0FFD,0,0,0,8'h00));
    tbl.push_back(mk(1,1,1,0,8'h00, 16'h0FFD,1,0,0,8'h00)); // abort, INC not taken
    tbl.push_back(mk(1,3,0,0,8'h00, 16'h0FFD,0,0,0,8'h00));
    tbl.push_back(mk(0,0,0,1,8'h11, 16'h0FFD,0,0,0,8'h00));
    tbl.push_back(mk(0,0,1,1,8'h22, 16'h0FFD,1,0,0,8'h00)); // abort on last beat
    tbl.push_back(mk(1,4,0,0,8'h00, 16'h0FFD,0,1,0,8'hFD));
    tbl.push_back(mk(0,0,1,0,8'h00, 16'h0FFD,1,0,0,8'h00)); // abort mid-OUT
    tbl.push_back(mk(1,5,0,0,8'h00, 16'h0FFD,1,0,0,8'h00)); // undefined op
    tbl.push_back(mk(0,1,0,0,8'h00, 16'h0FFD,1,0,0,8'h00)); // op without valid
    tbl.push_back(mk(1,0,0,0,8'h00, 16'h0FFD,1,0,0,8'h00)); // NOP

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_main", obs_m(), pk(1,0,0,8'h00,16'h0000));
    check("rst_sp32", {32'b0, if32.sp_addr_o}, 64'h1000);
    check("rst_sp8",  {56'b0, if8.sp_addr_o},  64'h80);
    rst_n = 1'b1;
    step();
    check("post_rst_main", obs_m(), pk(1,0,0,8'h00,16'h0000));

    foreach (tbl[i]) begin
      drive_m(tbl[i].v, tbl[i].op, tbl[i].ab, tbl[i].dv, tbl[i].d);
      step();
      check($sformatf("tbl[%0d]", i), obs_m(),
            pk(tbl[i].rdy, tbl[i].oe, tbl[i].wr, tbl[i].q, tbl[i].sp));
    end
    drive_m(0, 0, 0, 0, 0);

    // 32-bit, STEP=2: back-to-back DEC from 0x1000
    for (int k = 1; k <= 3; k++) begin
      drive_32(1, 3'd2, 0, 0);
      step();
      check($sformatf("u32_dec%0d", k), {32'b0, if32.sp_addr_o}, 64'(32'h1000 - 2*k));
    end
    // 4-beat LOAD
    exp32 = 32'hDEAD_BEEF;
    drive_32(1, 3'd3, 0, 0);
    step();
    for (int k = 0; k < 4; k++) begin
      drive_32(0, 0, 1, 8'((exp32 >> (8*k)) & 32'hFF));
      step();
      check($sformatf("u32_load%0d", k), {32'b0, if32.sp_addr_o},
            (k == 3) ? 64'(exp32) : 64'h0FFA);
    end
    // 4-beat OUT
    drive_32(1, 3'd4, 0, 0);
    step();
    drive_32(0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("u32_out%0d", k), {55'b0, if32.dat_oe_o, if32.dat_o},
            {55'b0, 1'b1, 8'((exp32 >> (8*k)) & 32'hFF)});
      step();
    end
    check("u32_out_end", {55'b0, if32.dat_oe_o, if32.dat_o}, 64'h0);

    // 8-bit: single-beat LOAD/OUT, then INC wrap
    drive_8(1, 3'd3, 0, 0); step();
    drive_8(0, 0, 1, 8'h5A); step();
    check("u8_load", {55'b0, if8.cmd_ready_o, if8.sp_addr_o}, {55'b0, 1'b1, 8'h5A});
    drive_8(1, 3'd4, 0, 0); step();
    drive_8(0, 0, 0, 0);
    check("u8_out", {55'b0, if8.dat_oe_o, if8.dat_o}, {55'b0, 1'b1, 8'h5A});
    step();
    check("u8_out_end", {55'b0, if8.dat_oe_o, if8.dat_o}, 64'h0);
    drive_8(1, 3'd3, 0, 0); step();
    drive_8(0, 0, 1, 8'hFF); step();
    drive_8(1, 3'd1, 0, 0); step();
    drive_8(0, 0, 0, 0);
    check("u8_wrap", {55'b0, if8.wrap_o, if8.sp_addr_o}, {55'b0, 1'b1, 8'h00});

    // reset pulse mid-LOAD on the 32-bit instance
    drive_32(1, 3'd3, 0, 0); step();
    drive_32(0, 0, 1, 8'h11); step();
    drive_32(0, 0, 1, 8'h22); step();
    #2 rst_n = 1'b0;
    #1;
    check("u32_rst_mid", {30'b0, if32.cmd_ready_o, if32.dat_oe_o, if32.sp_addr_o},
          {30'b0, 1'b1, 1'b0, 32'h0000_1000});
    check("u8_rst_wrap", {63'b0, if8.wrap_o}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive_32(0, 0, 1, 8'h33); step();
    drive_32(0, 0, 1, 8'h44); step();
    drive_32(0, 0, 0, 0);
    check("u32_no_commit", {32'b0, if32.sp_addr_o}, 64'h1000);

    // randomized run on the main instance against the model
    m_sp = 0; m_wrap = 0; m_mode = 0; m_loadq.delete(); m_outq.delete();
    for (int i = 0; i < 400; i++) begin
      check($sformatf("rand[%0d]", i), obs_m(), model_obs());
      drive_m(($urandom % 4) != 0, 3'($urandom_range(0, 7)), ($urandom % 12) == 0,
              ($urandom % 3) != 0, 8'($urandom));
      @(posedge clk);
      model_step();
      #1;
    end
    check("rand_final", obs_m(), model_obs());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
